// File: rtl/led_chase_scorer_pkg.sv
// rtl/led_chase_scorer_pkg.sv - shared state encoding, glyphs and BCD helper for the scorer
package led_chase_scorer_pkg;

   typedef enum logic [1:0] {
      ARMED     = 2'd0,
      LOCKED    = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   localparam int REFRESH_DIV_DEF = 50000;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Nibble codes fed to the decoder for the non-numeric glyphs
   localparam logic [3:0] NIB_E     = 4'hE;
   localparam logic [3:0] NIB_BLANK = 4'hF;

   // Three-digit packed BCD increment that sticks at 999 instead of wrapping
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v != 12'h999) begin
         if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
               r[7:4]  = 4'd0;
               r[11:8] = v[11:8] + 4'd1;
            end else begin
               r[7:4] = v[7:4] + 4'd1;
            end
         end else begin
            r[3:0] = v[3:0] + 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/led_chase_scorer_if.sv
// rtl/led_chase_scorer_if.sv - game input/result bundle between the chaser top level and the scorer
interface led_chase_scorer_if;
   logic [23:0] led_vec;
   logic        hit;
   logic        round_clr;
   logic [11:0] score;
   logic [3:0]  misses;
   logic        game_over;

   modport master (
      output led_vec, hit, round_clr,
      input  score, misses, game_over
   );

   modport slave (
      input  led_vec, hit, round_clr,
      output score, misses, game_over
   );
endinterface

// File: rtl/led_chase_scorer_seg7_decode.sv
// rtl/led_chase_scorer_seg7_decode.sv - nibble to active-low seven-segment glyph
module seg7_decode
   import led_chase_scorer_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Digits 0..9, 'E' on code E, everything else blank
   always_comb begin
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         NIB_E:   seg = SEG_E;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/led_chase_scorer.sv
// rtl/led_chase_scorer.sv - hit scoring FSM with BCD score, miss limit and 4-digit display scan
module led_chase_scorer
   import led_chase_scorer_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEF,
   parameter int MAX_MISS    = 3
)
(
   input  logic                CLK,
   input  logic                RST,
   led_chase_scorer_if.slave   bus,
   output logic [3:0]          AN,
   output logic [6:0]          SEG
);

   localparam int             CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  TERM      = CW'(REFRESH_DIV - 1);
   localparam logic [3:0]     MISS_LAST = 4'(MAX_MISS - 1);

   state_t        state;
   state_t        state_nxt;
   logic [11:0]   score_q;
   logic [3:0]    miss_q;
   logic [23:0]   lock_val;
   logic          award;
   logic          miss;
   logic          led_any;
   logic          led_moved;
   logic          miss_ends;
   logic [CW-1:0] ref_cnt;
   logic [1:0]    dig_idx;
   logic [3:0]    dig_val;
   logic [6:0]    seg_c;

   // Qualifiers shared by the next-state and output decode
   always_comb begin
      led_any   = |bus.led_vec;
      led_moved = (bus.led_vec != lock_val);
      miss_ends = (miss_q == MISS_LAST);
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ARMED;
      else     state <= state_nxt;
   end

   // Next state: round_clr dominates; the ending miss wins over a chaser step
   always_comb begin
      state_nxt = state;
      if (bus.round_clr) begin
         state_nxt = ARMED;
      end else begin
         case (state)
            ARMED: begin
               if (bus.hit) begin
                  if (led_any)        state_nxt = LOCKED;
                  else if (miss_ends) state_nxt = GAME_OVER;
               end
            end
            LOCKED: begin
               if (bus.hit && miss_ends) state_nxt = GAME_OVER;
               else if (led_moved)       state_nxt = ARMED;
            end
            GAME_OVER: state_nxt = GAME_OVER;
            default:   state_nxt = ARMED;
         endcase
      end
   end

   // Outputs of the FSM: point award and miss strobes, suppressed by round_clr
   always_comb begin
      award = 1'b0;
      miss  = 1'b0;
      if (!bus.round_clr) begin
         case (state)
            ARMED: begin
               award = bus.hit & led_any;
               miss  = bus.hit & ~led_any;
            end
            LOCKED:  miss = bus.hit;
            default: ;
         endcase
      end
   end

   // Score, miss counter and locked LED position
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         score_q  <= 12'h000;
         miss_q   <= 4'd0;
         lock_val <= 24'd0;
      end else if (bus.round_clr) begin
         score_q  <= 12'h000;
         miss_q   <= 4'd0;
         lock_val <= 24'd0;
      end else begin
         if (award) begin
            score_q  <= bcd_inc(score_q);
            lock_val <= bus.led_vec;
         end
         if (miss) miss_q <= miss_q + 4'd1;
      end
   end

   assign bus.score     = score_q;
   assign bus.misses    = miss_q;
   assign bus.game_over = (state == GAME_OVER);

   // Refresh divider and digit slot index
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ref_cnt <= '0;
         dig_idx <= 2'd0;
      end else if (ref_cnt == TERM) begin
         ref_cnt <= '0;
         dig_idx <= dig_idx + 2'd1;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // Select the nibble shown in the current digit slot
   always_comb begin
      case (dig_idx)
         2'd0:    dig_val = score_q[3:0];
         2'd1:    dig_val = score_q[7:4];
         2'd2:    dig_val = (state == GAME_OVER) ? NIB_E : NIB_BLANK;
         default: dig_val = miss_q;
      endcase
   end

   seg7_decode u_seg7_decode (
      .nibble (dig_val),
      .seg    (seg_c)
   );

   // Registered anode and segment drive, blank while in reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         AN  <= 4'b1111;
         SEG <= SEG_BLANK;
      end else begin
         AN  <= ~(4'b0001 << dig_idx);
         SEG <= seg_c;
      end
   end

endmodule

// File: tb/tb_led_chase_scorer.sv
// tb/tb_led_chase_scorer.sv - randomized and directed bench for led_chase_scorer against a behavioural model
module tb_led_chase_scorer;

   localparam int RDIV  = 4;
   localparam int MMISS = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] an;
   logic [6:0] seg;

   led_chase_scorer_if bus ();

   led_chase_scorer #(
      .REFRESH_DIV (RDIV),
      .MAX_MISS    (MMISS)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus),
      .AN  (an),
      .SEG (seg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int          m_score;
   int          m_misses;
   bit          m_locked;
   bit          m_over;
   logic [23:0] m_lock;
   int          edge_no;

   logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_score  = 0;
      m_misses = 0;
      m_locked = 0;
      m_over   = 0;
      m_lock   = '0;
   endtask

   task automatic model_update(input logic [23:0] led, input bit h, input bit rc);
      if (rc) begin
         model_reset();
      end else if (!m_over) begin
         if (!m_locked) begin
            if (h) begin
               if (led != 0) begin
                  if (m_score < 999) m_score++;
                  m_lock   = led;
                  m_locked = 1;
               end else begin
                  m_misses++;
                  if (m_misses == MMISS) m_over = 1;
               end
            end
         end else begin
            if (h) begin
               m_misses++;
               if (m_misses == MMISS) begin
                  m_over   = 1;
                  m_locked = 0;
               end
            end
            if (!m_over && led != m_lock) m_locked = 0;
         end
      end
   endtask

   // One clock: drive at the falling edge, predict, check 1 ns after the rising edge
   task automatic step(input logic [23:0] led, input bit h, input bit rc);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      int         d;
      @(negedge clk);
      bus.led_vec   = led;
      bus.hit       = h;
      bus.round_clr = rc;
      edge_no++;
      d = ((edge_no - 1) / RDIV) % 4;
      case (d)
         0: begin e_an = 4'b1110; e_seg = glyph[m_score % 10]; end
         1: begin e_an = 4'b1101; e_seg = glyph[(m_score / 10) % 10]; end
         2: begin e_an = 4'b1011; e_seg = m_over ? 7'b0000110 : 7'b1111111; end
         default: begin e_an = 4'b0111; e_seg = glyph[m_misses]; end
      endcase
      model_update(led, h, rc);
      @(posedge clk);
      #1;
      check_val("score",     32'(bus.score),     32'(to_bcd(m_score)));
      check_val("misses",    32'(bus.misses),    32'(m_misses));
      check_val("game_over", 32'(bus.game_over), 32'(m_over));
      check_val("AN",        32'(an),            32'(e_an));
      check_val("SEG",       32'(seg),           32'(e_seg));
   endtask

   task automatic earn_points(input int n);
      for (int i = 0; i < n; i++) begin
         step(24'h1 << (i % 24), 1'b1, 1'b0);
         step(24'h1 << ((i + 1) % 24), 1'b0, 1'b0);
      end
   endtask

   logic [23:0] prev_led;
   logic [23:0] r_led;
   bit          r_hit;
   bit          r_rc;
   int          r;

   initial begin
      bus.led_vec   = '0;
      bus.hit       = 1'b0;
      bus.round_clr = 1'b0;
      model_reset();
      edge_no = 0;

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_AN",    32'(an),         32'h0000000f);
      check_val("rst_SEG",   32'(seg),        32'h0000007f);
      check_val("rst_score", 32'(bus.score),  32'h0);
      rst = 1'b0;

      // Idle scan over all four digits
      repeat (4 * RDIV) step(24'h0, 1'b0, 1'b0);

      // Hit, double press, stepped hit
      step(24'h000004, 1'b1, 1'b0);
      step(24'h000004, 1'b1, 1'b0);
      step(24'h000008, 1'b0, 1'b0);
      step(24'h000008, 1'b1, 1'b0);
      check_val("score_002", 32'(bus.score), 32'h002);

      // Misses to game over, then ignored hits
      repeat (3) step(24'h0, 1'b1, 1'b0);
      check_val("over_set", 32'(bus.game_over), 32'h1);
      step(24'h000010, 1'b1, 1'b0);
      repeat (4 * RDIV) step(24'h0, 1'b0, 1'b0);

      // Saturation at 999 and lock on the suppressed increment
      step(24'h0, 1'b0, 1'b1);
      earn_points(999);
      step(24'h000020, 1'b1, 1'b0);
      check_val("sat_999", 32'(bus.score), 32'h999);
      step(24'h000020, 1'b1, 1'b0);

      // round_clr beats a simultaneous hit
      step(24'h0, 1'b0, 1'b1);
      earn_points(5);
      step(24'h000040, 1'b1, 1'b1);
      check_val("clr_wins", 32'(bus.score), 32'h000);
      step(24'h000040, 1'b1, 1'b0);

      // Randomized play
      prev_led = '0;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)      r_led = '0;
         else if (r < 7) r_led = prev_led;
         else            r_led = 24'h1 << $urandom_range(0, 23);
         r_hit = ($urandom_range(0, 2) == 0);
         r_rc  = ($urandom_range(0, 39) == 0);
         prev_led = r_led;
         step(r_led, r_hit, r_rc);
      end

      // Asynchronous reset mid-scan with score 042
      step(24'h0, 1'b0, 1'b1);
      earn_points(42);
      repeat (5) step(24'h0, 1'b0, 1'b0);
      check_val("pre_rst_score", 32'(bus.score), 32'h042);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_AN",    32'(an),        32'h0000000f);
      check_val("async_SEG",   32'(seg),       32'h0000007f);
      check_val("async_score", 32'(bus.score), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      edge_no = 0;
      repeat (2 * RDIV) step(24'h0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
